mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-ported, byte-addressed 16-bit memory (comb read, write on posedge, no concurrent rd/wr) between fetch (I, read-only) and load/store (D) requesters.
// - One-entry holding register per port; at most one memory access per cycle; responses are registered.
// - Sits between the fetch/memory pipeline stages and the unified memory instance.
// PARAMETERS
// ADDR_WIDTH  16  byte-address width for both ports and the memory
// DATA_WIDTH  16  word width; fixed at 16, any other value is a config error
// STARVE_MAX  4   consecutive lost cycles with I pending before I is forced to win (1..15)
// PORTS
// clk        in   1   clock, all state updates on posedge
// rst        in   1   synchronous reset, active-low (rst==0 resets)
// i_req      in   1   fetch request valid
// i_addr     in   AW  fetch byte address
// i_ready    out  1   I holding register can accept this cycle
// i_rvalid   out  1   one-cycle pulse: i_rdata valid
// i_rdata    out  16  fetched word
// d_req      in   1   data request valid
// d_wr       in   1   1=store, 0=load
// d_addr     in   AW  data byte address
// d_wdata    in   16  store data
// d_ready    out  1   D holding register can accept this cycle
// d_ack      out  1   one-cycle pulse: D access complete (load data or store done)
// d_rdata    out  16  load data, valid with d_ack on loads, 0 on stores
// d_err      out  1   with d_ack: d_addr[0]==1, access was suppressed
// mem_en     out  1   memory enable
// mem_wr     out  1   memory write
// mem_addr   out  AW  memory byte address
// mem_wdata  out  16  memory write data
// mem_rdata  in   16  memory read data (combinational from mem_addr)
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-low.
// - Reset (rst==0 at posedge): pend_i=pend_d=0, starve counter=0, rr pointer=D; all outputs 0 from the next cycle. mem_en is also forced 0 in any cycle rst==0. In-flight requests are dropped, no ack.
// - Accept: transfer when req && ready. x_ready = !pend_x || gnt_x (slot freed by this cycle's grant). Captured at posedge; pend_x set.
// - Issue: each cycle with any pend set, exactly one granted; mem_en=1, mem_addr/mem_wr/mem_wdata from granted holding reg. No grant -> mem_en=0, mem_wr=0, addr/wdata 0.
// - Response: granted access's result registered at posedge; rvalid/ack high the following cycle for exactly 1 cycle; rdata holds mem_rdata sampled at the grant edge, 0 otherwise.
// - Latency: req accepted at edge E -> issued cycle after E -> rvalid/ack visible 2 cycles after request cycle. Throughput 1 access/cycle total.
// - Priority (default): D wins when both pending. Counter increments each cycle I pending and loses, clears when I granted or not pending; at count==STARVE_MAX I wins that cycle.
// - Misaligned (addr[0]==1): D: granted normally but mem_en=0 that cycle; d_ack with d_err=1, d_rdata=0, no write. I: i_rvalid with i_rdata=0 (fetch misalign is flagged upstream).
// - Simultaneous: accept and grant on same port same cycle -> new entry replaces the granted one; no bubble.
// - Counter saturates at STARVE_MAX; never wraps.
// CONFIGURATION
// - MEM_ARB_RR_EN defined: fixed-priority + starve counter removed; strict round-robin, pointer toggles to the other port after each grant when both pending; first contention after reset goes to D.
// - Undefined: fixed D priority with STARVE_MAX anti-starvation as above.
// TESTING
// - Reset: hold rst=0 2 cycles with i_req=d_req=1 -> mem_en=0, all acks 0, ready=1 after release.
// - Lone load: d_req, d_addr=0x0010, mem[0x0010]=0xBEEF -> mem_en 1 cycle later, d_ack+d_rdata=0xBEEF 2 cycles after req.
// - Store then load: store 0x1234 to 0x0020, then load 0x0020 -> d_ack, d_err=0, load returns 0x1234.
// - Contention (default): both req every cycle, STARVE_MAX=4 -> grant sequence D,D,D,D,I repeating; no I loss >4 cycles.
// - MEM_ARB_RR_EN: same stimulus -> grants alternate D,I,D,I.
// - Misaligned store d_addr=0x0031 -> mem_en=0, d_ack with d_err=1, mem[0x0030] unchanged; rst=0 mid-pending -> no ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch I / load-store D) arbiter sharing one single-ported 16-bit memory.
// Define MEM_ARB_RR_EN for strict round-robin; default is D priority with I anti-starvation.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    generate
        if (DATA_WIDTH != 16) begin : g_dw_check
            $error("mem_port_arbiter: DATA_WIDTH must be 16");
        end
        if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_check
            $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
        end
    endgenerate

    // Holding registers, one entry per port
    logic          pend_i_reg;
    logic [AW-1:0] i_addr_reg;
    logic          pend_d_reg;
    logic          d_wr_reg;
    logic [AW-1:0] d_addr_reg;
    logic [DW-1:0] d_wdata_reg;

    // Registered responses
    logic          i_rvalid_reg;
    logic [DW-1:0] i_rdata_reg;
    logic          d_ack_reg;
    logic [DW-1:0] d_rdata_reg;
    logic          d_err_reg;

    logic gnt_i;
    logic gnt_d;
    logic i_mis;
    logic d_mis;
    logic both_pend;

    assign i_mis     = i_addr_reg[0];
    assign d_mis     = d_addr_reg[0];
    assign both_pend = pend_i_reg && pend_d_reg;

`ifdef MEM_ARB_RR_EN
    // 1 means I takes the next contended cycle; reset favours D.
    logic rr_i_reg;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (rst) begin
            if (both_pend) begin
                gnt_i = rr_i_reg;
                gnt_d = !rr_i_reg;
            end else begin
                gnt_i = pend_i_reg;
                gnt_d = pend_d_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_i_reg <= 1'b0;
        end else if (both_pend) begin
            rr_i_reg <= !rr_i_reg;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_reg;
    logic       starve_force;

    assign starve_force = (starve_cnt_reg == STARVE_LIM);

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (rst) begin
            if (both_pend) begin
                gnt_i = starve_force;
                gnt_d = !starve_force;
            end else begin
                gnt_i = pend_i_reg;
                gnt_d = pend_d_reg;
            end
        end
    end

    // Counts consecutive cycles I waited while pending; saturates at the limit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_reg <= 4'd0;
        end else if (pend_i_reg && !gnt_i) begin
            if (!starve_force) begin
                starve_cnt_reg <= starve_cnt_reg + 4'd1;
            end
        end else begin
            starve_cnt_reg <= 4'd0;
        end
    end
`endif

    // A slot granted this cycle frees up, so a new request can land in the same edge.
    assign i_ready = rst && (!pend_i_reg || gnt_i);
    assign d_ready = rst && (!pend_d_reg || gnt_d);

    // Memory port drive; a misaligned D access is granted but never reaches memory.
    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_d) begin
            if (!d_mis) begin
                mem_en    = 1'b1;
                mem_wr    = d_wr_reg;
                mem_addr  = d_addr_reg;
                mem_wdata = d_wr_reg ? d_wdata_reg : '0;
            end
        end else if (gnt_i) begin
            mem_en   = 1'b1;
            mem_addr = i_addr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_i_reg <= 1'b0;
            i_addr_reg <= '0;
        end else if (i_req && i_ready) begin
            pend_i_reg <= 1'b1;
            i_addr_reg <= i_addr;
        end else if (gnt_i) begin
            pend_i_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_d_reg  <= 1'b0;
            d_wr_reg    <= 1'b0;
            d_addr_reg  <= '0;
            d_wdata_reg <= '0;
        end else if (d_req && d_ready) begin
            pend_d_reg  <= 1'b1;
            d_wr_reg    <= d_wr;
            d_addr_reg  <= d_addr;
            d_wdata_reg <= d_wdata;
        end else if (gnt_d) begin
            pend_d_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            i_rvalid_reg <= 1'b0;
            i_rdata_reg  <= '0;
            d_ack_reg    <= 1'b0;
            d_rdata_reg  <= '0;
            d_err_reg    <= 1'b0;
        end else begin
            i_rvalid_reg <= gnt_i;
            i_rdata_reg  <= (gnt_i && !i_mis) ? mem_rdata : '0;
            d_ack_reg    <= gnt_d;
            d_rdata_reg  <= (gnt_d && !d_wr_reg && !d_mis) ? mem_rdata : '0;
            d_err_reg    <= gnt_d && d_mis;
        end
    end

    assign i_rvalid = i_rvalid_reg;
    assign i_rdata  = i_rdata_reg;
    assign d_ack    = d_ack_reg;
    assign d_rdata  = d_rdata_reg;
    assign d_err    = d_err_reg;

endmodule
